// File: rtl/seg_reader_pkg.sv
// Shared 7-segment constants, frame classes and BCD helpers.
// Used by the segment reader and by the display encoder side.
package seg_reader_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [31:0] FRAME_BLANK = {4{SEG_BLANK}};
    localparam logic [31:0] FRAME_DASH  = {4{SEG_DASH}};

    typedef enum logic [1:0] {
        CLS_DIGITS  = 2'd0,
        CLS_BLANK   = 2'd1,
        CLS_DASH    = 2'd2,
        CLS_INVALID = 2'd3
    } frame_class_e;

    // Digit to active-low segment code, for the encoder side.
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] c;
        c = SEG_BLANK;
        case (d)
            4'd0: c = SEG_0;
            4'd1: c = SEG_1;
            4'd2: c = SEG_2;
            4'd3: c = SEG_3;
            4'd4: c = SEG_4;
            4'd5: c = SEG_5;
            4'd6: c = SEG_6;
            4'd7: c = SEG_7;
            4'd8: c = SEG_8;
            4'd9: c = SEG_9;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Four-digit BCD minus one with borrow; 0000 wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Exact-match decode of one active-low segment bus.
// Any code outside the ten digit patterns is a non-digit.
module seg_digit_decode
    import seg_reader_pkg::*;
(
    input  logic [7:0] code_i,
    output logic [3:0] digit_o,
    output logic       is_digit_o
);

    // Map a full 8-bit code to its digit value
    always_comb begin
        digit_o    = 4'd0;
        is_digit_o = 1'b1;
        unique case (code_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Reads a 4-digit 7-segment display, filters flicker and
// reports frame class, BCD value, frame period and countdown steps.
module seg_reader
    import seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_WIDTH  = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              hex0,
    input  logic [7:0]              hex1,
    input  logic [7:0]              hex2,
    input  logic [7:0]              hex3,
    output logic                    frame_valid,
    output logic [1:0]              frame_class,
    output logic [15:0]             bcd,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    step_ok,
    output logic                    step_err
);

    localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_FIRST = 1'b0,
        S_TRACK = 1'b1
    } state_e;

    logic [31:0]             frame_w;
    logic [15:0]             dig_w;
    logic [3:0]              isd_w;
    frame_class_e            cls_w;
    logic [15:0]             bcd_w;
    logic                    same_w;
    logic                    accept_w;
    logic                    ok_w;
    logic                    err_w;

    logic [31:0]             sample_q;
    logic [7:0]              stab_q;
    logic [7:0]              stab_d;
    state_e                  state_q;
    logic [31:0]             last_q;
    logic [PERIOD_WIDTH-1:0] per_q;
    logic [PERIOD_WIDTH-1:0] per_d;

    logic                    fv_q;
    frame_class_e            cls_q;
    logic [15:0]             bcd_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    ok_q;
    logic                    err_q;

    assign frame_w = {hex3, hex2, hex1, hex0};

    seg_digit_decode u_dec0 (
        .code_i     (hex0),
        .digit_o    (dig_w[3:0]),
        .is_digit_o (isd_w[0])
    );

    seg_digit_decode u_dec1 (
        .code_i     (hex1),
        .digit_o    (dig_w[7:4]),
        .is_digit_o (isd_w[1])
    );

    seg_digit_decode u_dec2 (
        .code_i     (hex2),
        .digit_o    (dig_w[11:8]),
        .is_digit_o (isd_w[2])
    );

    seg_digit_decode u_dec3 (
        .code_i     (hex3),
        .digit_o    (dig_w[15:12]),
        .is_digit_o (isd_w[3])
    );

    // Classify the live frame and decide acceptance and step result
    always_comb begin
        cls_w = CLS_INVALID;
        if (&isd_w) begin
            cls_w = CLS_DIGITS;
        end else if (frame_w == FRAME_BLANK) begin
            cls_w = CLS_BLANK;
        end else if (frame_w == FRAME_DASH) begin
            cls_w = CLS_DASH;
        end

        bcd_w = (cls_w == CLS_DIGITS) ? dig_w : 16'h0000;

        same_w = (frame_w == sample_q);
        stab_d = 8'd1;
        if (same_w) begin
            stab_d = (stab_q == STAB_TGT) ? stab_q : stab_q + 8'd1;
        end

        // The counter is pinned at the target, so this fires once per run
        accept_w = same_w && (stab_q == STAB_PRE) &&
                   ((state_q == S_FIRST) || (frame_w != last_q));

        per_d = (per_q == '1) ? per_q : per_q + PERIOD_WIDTH'(1);

        ok_w  = 1'b0;
        err_w = 1'b0;
        if ((state_q == S_TRACK) && (cls_q == CLS_DIGITS) &&
            (cls_w == CLS_DIGITS)) begin
            // 0000 has no valid predecessor step, so it never counts as ok
            if ((bcd_q != 16'h0000) && (bcd_w == bcd_dec(bcd_q))) begin
                ok_w = 1'b1;
            end else begin
                err_w = 1'b1;
            end
        end
    end

    // Stability filter: previous sample and run length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= '1;
            stab_q   <= '0;
        end else begin
            sample_q <= frame_w;
            stab_q   <= stab_d;
        end
    end

    // Acceptance FSM with registered frame outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FIRST;
            last_q   <= '1;
            per_q    <= '0;
            fv_q     <= 1'b0;
            cls_q    <= CLS_DIGITS;
            bcd_q    <= '0;
            period_q <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fv_q  <= 1'b0;
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            per_q <= per_d;
            if (accept_w) begin
                state_q  <= S_TRACK;
                last_q   <= frame_w;
                per_q    <= PERIOD_WIDTH'(1);
                period_q <= (state_q == S_FIRST) ? '0 : per_q;
                fv_q     <= 1'b1;
                cls_q    <= cls_w;
                bcd_q    <= bcd_w;
                ok_q     <= ok_w;
                err_q    <= err_w;
            end
        end
    end

    assign frame_valid = fv_q;
    assign frame_class = cls_q;
    assign bcd         = bcd_q;
    assign period      = period_q;
    assign step_ok     = ok_q;
    assign step_err    = err_q;

endmodule
